// File: rtl/hyperbus_rx_upsizer.sv
// Packs 16-bit or 16*NumPhys-bit HyperBus read beats into AXI-width words,
// buffering completed words in a small in-order FIFO.
module hyperbus_rx_upsizer #(
    parameter int NumPhys      = 2,
    parameter int AxiDataWidth = 64,
    parameter int FifoDepth    = 2
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  phys_in_use_i,
    input  logic [16*NumPhys-1:0]                 rx_data_i,
    input  logic                                  rx_last_i,
    input  logic                                  rx_error_i,
    input  logic                                  rx_valid_i,
    output logic                                  rx_ready_o,
    output logic [AxiDataWidth-1:0]               out_data_o,
    output logic                                  out_last_o,
    output logic                                  out_error_o,
    output logic [$clog2(AxiDataWidth/16):0]      out_beats_o,
    output logic                                  out_valid_o,
    input  logic                                  out_ready_i,
    output logic                                  busy_o
);
    localparam int BwMax   = 16 * NumPhys;
    localparam int RSingle = AxiDataWidth / 16;
    localparam int RDual   = AxiDataWidth / BwMax;
    localparam int CntW    = $clog2(AxiDataWidth / 16) + 1;
    localparam int PtrW    = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int OccW    = $clog2(FifoDepth + 1);

    typedef enum logic {IDLE, FILL} state_e;

    state_e                  state;
    logic [CntW-1:0]         cnt;
    logic                    mode_q;
    logic                    err_acc;
    logic [AxiDataWidth-1:0] acc;

    logic                    accept;
    logic                    mode_cur;
    logic [AxiDataWidth-1:0] beat_ext;
    logic [AxiDataWidth-1:0] word_nxt;
    logic [CntW-1:0]         cnt_inc;
    logic [CntW-1:0]         r_eff;
    logic                    completing;
    logic                    err_nxt;
    int                      shamt;

    // Mode is taken live on the first beat of a word, then frozen in mode_q.
    always_comb begin
        accept   = rx_valid_i & rx_ready_o;
        mode_cur = (state == IDLE) ? phys_in_use_i : mode_q;
        beat_ext = '0;
        beat_ext[15:0] = rx_data_i[15:0];
        if (mode_cur) beat_ext[BwMax-1:0] = rx_data_i;
        shamt      = int'(cnt) * (mode_cur ? BwMax : 16);
        word_nxt   = ((state == IDLE) ? '0 : acc) | (beat_ext << shamt);
        cnt_inc    = cnt + 1'b1;
        r_eff      = mode_cur ? CntW'(RDual) : CntW'(RSingle);
        completing = rx_last_i | (cnt_inc == r_eff);
        err_nxt    = ((state == FILL) & err_acc) | rx_error_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            cnt     <= '0;
            mode_q  <= 1'b0;
            err_acc <= 1'b0;
            acc     <= '0;
        end else if (accept) begin
            if (state == IDLE) mode_q <= phys_in_use_i;
            if (completing) begin
                state   <= IDLE;
                cnt     <= '0;
                err_acc <= 1'b0;
                acc     <= '0;
            end else begin
                state   <= FILL;
                cnt     <= cnt_inc;
                err_acc <= err_nxt;
                acc     <= word_nxt;
            end
        end
    end

    logic                    push, pop;
    logic [PtrW-1:0]         wr_ptr, rd_ptr;
    logic [OccW-1:0]         occ, occ_nxt;
    logic [AxiDataWidth-1:0] mem_data  [FifoDepth];
    logic                    mem_last  [FifoDepth];
    logic                    mem_err   [FifoDepth];
    logic [CntW-1:0]         mem_beats [FifoDepth];

    always_comb begin
        push    = accept & completing;
        pop     = out_valid_o & out_ready_i;
        occ_nxt = occ;
        if (push && !pop)      occ_nxt = occ + 1'b1;
        else if (pop && !push) occ_nxt = occ - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_data[wr_ptr]  <= word_nxt;
            mem_last[wr_ptr]  <= rx_last_i;
            mem_err[wr_ptr]   <= err_nxt;
            mem_beats[wr_ptr] <= cnt_inc;
        end
    end

    // Ready is registered from next occupancy, so a pop never raises it combinationally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            rx_ready_o <= 1'b0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PtrW'(FifoDepth - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == PtrW'(FifoDepth - 1)) ? '0 : rd_ptr + 1'b1;
            occ        <= occ_nxt;
            rx_ready_o <= (occ_nxt < OccW'(FifoDepth));
        end
    end

    assign out_valid_o = (occ != '0);
    assign out_data_o  = out_valid_o ? mem_data[rd_ptr]  : '0;
    assign out_last_o  = out_valid_o ? mem_last[rd_ptr]  : 1'b0;
    assign out_error_o = out_valid_o ? mem_err[rd_ptr]   : 1'b0;
    assign out_beats_o = out_valid_o ? mem_beats[rd_ptr] : '0;
    assign busy_o      = (state == FILL) | out_valid_o;

endmodule

// File: tb/tb_hyperbus_rx_upsizer.sv
// Directed bench for hyperbus_rx_upsizer (2 PHYs, 64-bit words, 2-entry FIFO).
module tb_hyperbus_rx_upsizer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        phys_in_use;
    logic [31:0] rx_data;
    logic        rx_last, rx_error, rx_valid, rx_ready;
    logic [63:0] out_data;
    logic        out_last, out_error, out_valid, out_ready, busy;
    logic [2:0]  out_beats;

    int total = 0;
    int bad   = 0;

    hyperbus_rx_upsizer #(.NumPhys(2), .AxiDataWidth(64), .FifoDepth(2)) dut (
        .clk_i(clk), .rst_ni(rst_n), .phys_in_use_i(phys_in_use),
        .rx_data_i(rx_data), .rx_last_i(rx_last), .rx_error_i(rx_error),
        .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
        .out_data_o(out_data), .out_last_o(out_last), .out_error_o(out_error),
        .out_beats_o(out_beats), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present one beat from a negedge and hold it until accepted (bounded).
    task automatic send(input logic mode, input logic [31:0] d, input logic last, input logic err);
        int n = 0;
        @(negedge clk);
        phys_in_use = mode; rx_data = d; rx_last = last; rx_error = err; rx_valid = 1'b1;
        while (!rx_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", {63'd0, rx_ready}, 64'd1);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Wait for a word, check it, then pop it with a one-cycle out_ready pulse.
    task automatic expect_word(input string tag, input logic [63:0] d, input logic last,
                               input logic err, input logic [2:0] beats);
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        chk({tag, "_data"},  out_data, d);
        chk({tag, "_last"},  {63'd0, out_last}, {63'd0, last});
        chk({tag, "_err"},   {63'd0, out_error}, {63'd0, err});
        chk({tag, "_beats"}, {61'd0, out_beats}, {61'd0, beats});
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; phys_in_use = 1'b1; rx_data = '0; rx_last = 1'b0;
        rx_error = 1'b0; rx_valid = 1'b0; out_ready = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_data",  out_data, 64'd0);
        chk("rst_beats", {61'd0, out_beats}, 64'd0);
        chk("rst_busy",  {63'd0, busy}, 64'd0);
        chk("rst_ready", {63'd0, rx_ready}, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 chk("post_rst_ready", {63'd0, rx_ready}, 64'd1);

        // dual mode, two beats, plus latency-1 check
        send(1'b1, 32'h1111_2222, 1'b0, 1'b0);
        send(1'b1, 32'h3333_4444, 1'b1, 1'b0);
        @(negedge clk);
        chk("dual_latency", {63'd0, out_valid}, 64'd1);
        rx_valid = 1'b0;
        expect_word("dual", 64'h3333_4444_1111_2222, 1'b1, 1'b0, 3'd2);

        // single mode: upper half of rx_data must be ignored, upper word bits zeroed
        send(1'b0, 32'hDEAD_AAAA, 1'b0, 1'b0);
        send(1'b0, 32'hBEEF_BBBB, 1'b0, 1'b0);
        send(1'b0, 32'h0000_CCCC, 1'b1, 1'b0);
        idle();
        expect_word("single", 64'h0000_CCCC_BBBB_AAAA, 1'b1, 1'b0, 3'd3);

        // error on beat 2 of a full 4-beat single word, clean next word
        send(1'b0, 32'h0001, 1'b0, 1'b0);
        send(1'b0, 32'h0002, 1'b0, 1'b1);
        send(1'b0, 32'h0003, 1'b0, 1'b0);
        send(1'b0, 32'h0004, 1'b0, 1'b0);
        send(1'b0, 32'h0005, 1'b0, 1'b0);
        send(1'b0, 32'h0006, 1'b1, 1'b0);
        idle();
        expect_word("err_w0", 64'h0004_0003_0002_0001, 1'b0, 1'b1, 3'd4);
        expect_word("err_w1", 64'h0000_0000_0006_0005, 1'b1, 1'b0, 3'd2);

        // back-pressure: FIFO fills after 4 dual beats, order preserved
        send(1'b1, 32'hA000_0001, 1'b0, 1'b0);
        send(1'b1, 32'hA000_0002, 1'b0, 1'b0);
        send(1'b1, 32'hA000_0003, 1'b0, 1'b0);
        #1 chk("bp_ready3", {63'd0, rx_ready}, 64'd1);
        send(1'b1, 32'hA000_0004, 1'b0, 1'b0);
        idle();
        chk("bp_full", {63'd0, rx_ready}, 64'd0);
        expect_word("bp_w0", 64'hA000_0002_A000_0001, 1'b0, 1'b0, 3'd2);
        send(1'b1, 32'hA000_0005, 1'b0, 1'b0);
        send(1'b1, 32'hA000_0006, 1'b1, 1'b0);
        idle();
        expect_word("bp_w1", 64'hA000_0004_A000_0003, 1'b0, 1'b0, 3'd2);
        expect_word("bp_w2", 64'hA000_0006_A000_0005, 1'b1, 1'b0, 3'd2);

        // mode change mid-word is ignored; next word takes the new mode
        send(1'b1, 32'h5555_6666, 1'b0, 1'b0);
        send(1'b0, 32'h7777_8888, 1'b0, 1'b0);
        send(1'b0, 32'hFFFF_9999, 1'b1, 1'b0);
        idle();
        expect_word("mode_w0", 64'h7777_8888_5555_6666, 1'b0, 1'b0, 3'd2);
        expect_word("mode_w1", 64'h0000_0000_0000_9999, 1'b1, 1'b0, 3'd1);

        // reset mid-word with a buffered word
        send(1'b1, 32'h0000_000A, 1'b0, 1'b0);
        send(1'b1, 32'h0000_000B, 1'b0, 1'b0);
        send(1'b1, 32'h0000_000C, 1'b0, 1'b0);
        idle();
        chk("pre_rst_busy",  {63'd0, busy}, 64'd1);
        chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_busy",  {63'd0, busy}, 64'd0);
        chk("mid_rst_ready", {63'd0, rx_ready}, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 chk("post_rst2_valid", {63'd0, out_valid}, 64'd0);
        send(1'b1, 32'h1234_5678, 1'b1, 1'b0);
        idle();
        expect_word("after_rst", 64'h0000_0000_1234_5678, 1'b1, 1'b0, 3'd1);
        chk("final_busy", {63'd0, busy}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hyperbus_rx_upsizer.md
HYPERBUS_RX_UPSIZER -- requirements
Module: hyperbus_rx_upsizer

Interface
REQ-001 SHALL have parameter NumPhys, default 2, meaning the number of PHYs; legal values are 1 and 2.
REQ-002 SHALL have parameter AxiDataWidth, default 64, meaning the output word width; legal values are a multiple of 16*NumPhys and at least 16*NumPhys.
REQ-003 SHALL have parameter FifoDepth, default 2, meaning the number of output buffer entries; minimum 1.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_ni, input, 1, reset that is asynchronous and active-low.
REQ-006 SHALL have port phys_in_use_i, input, 1: 0 = single PHY (16-bit beats), 1 = all PHYs (16*NumPhys-bit beats).
REQ-007 SHALL have port rx_data_i, input, 16*NumPhys, the PHY read beat; only bits [15:0] are used in single mode.
REQ-008 SHALL have port rx_last_i, input, 1, marking the final beat of a burst.
REQ-009 SHALL have port rx_error_i, input, 1, the beat error flag.
REQ-010 SHALL have port rx_valid_i, input, 1, and port rx_ready_o, output, 1, forming the beat handshake.
REQ-011 SHALL have port out_data_o, output, AxiDataWidth, the packed word.
REQ-012 SHALL have port out_last_o, output, 1, and port out_error_o, output, 1.
REQ-013 SHALL have port out_beats_o, output, $clog2(AxiDataWidth/16)+1, the number of valid beats in the word.
REQ-014 SHALL have port out_valid_o, output, 1, and port out_ready_i, input, 1, forming the word handshake.
REQ-015 SHALL have port busy_o, output, 1, high when a partial word or any FIFO entry is held.

Function
REQ-016 SHALL accept a beat only on a cycle where rx_valid_i and rx_ready_o are both high.
REQ-017 SHALL transfer a word only on a cycle where out_valid_o and out_ready_i are both high.
REQ-018 SHALL define BW = 16*NumPhys in dual mode and BW = 16 in single mode, and R = AxiDataWidth/BW.
REQ-019 SHALL sample phys_in_use_i on acceptance of the first beat of each word and hold that mode for the remainder of the word; changes mid-word are ignored.
REQ-020 SHALL place the k-th beat of a word (k from 0) at out_data_o bits [k*BW +: BW].
REQ-021 SHALL zero all bits above the last written beat of a word.
REQ-022 SHALL complete a word when its R-th beat is accepted, or earlier when a beat with rx_last_i high is accepted.
REQ-023 SHALL set out_last_o to the rx_last_i of the completing beat.
REQ-024 SHALL set out_error_o to the OR of rx_error_i over all beats of the word.
REQ-025 SHALL set out_beats_o to the number of beats packed into the word (1..R).
REQ-026 SHALL push a completed word into the FIFO in the same cycle as the completing beat is accepted, and SHALL assert out_valid_o on the next cycle (latency 1); no combinational path exists from rx to out.
REQ-027 SHALL drive rx_ready_o = (FIFO occupancy < FifoDepth); a pop in the same cycle does not raise ready.
REQ-028 SHALL allow a simultaneous push and pop when the FIFO is not full, leaving occupancy unchanged.
REQ-029 SHALL keep the FIFO in order, with pointers wrapping modulo FifoDepth (non-power-of-two depth is legal).
REQ-030 SHALL sustain one beat per cycle when out_ready_i is held high.
REQ-031 SHALL keep out_data_o, out_last_o, out_error_o and out_beats_o stable while out_valid_o is high and out_ready_i is low.
REQ-032 SHALL run the packer FSM with states IDLE (beat count 0) and FILL (count 1..R-1):
- IDLE to FILL on accepting a non-completing beat;
- FILL to IDLE on accepting a completing beat;
- IDLE to IDLE on accepting a beat that is completing by itself (R=1 or rx_last_i high).

Reset
REQ-033 SHALL, while rst_ni is low, clear the FIFO and the beat count, force FSM=IDLE and clear the latched mode and the error accumulator.
REQ-034 SHALL, during reset, drive out_valid_o=0, out_data_o=0, out_last_o=0, out_error_o=0, out_beats_o=0, busy_o=0 and rx_ready_o=0.
REQ-035 SHALL drive rx_ready_o=1 from the first rising edge after reset deassertion.
REQ-036 SHALL discard any partial word and FIFO contents when reset is asserted mid-operation, with no word emitted afterwards.

Verification
REQ-037 SHALL be verified with NumPhys=2, AxiDataWidth=64 in dual mode: beats 0x1111_2222 then 0x3333_4444 (last) -> one word 0x3333_4444_1111_2222 with last=1, beats=2, error=0.
REQ-038 SHALL be verified in the same configuration in single mode: beats 0xAAAA, 0xBBBB, 0xCCCC (last) -> word 0x0000_CCCC_BBBB_AAAA with beats=3 and last=1.
REQ-039 SHALL be verified with a 4-beat single-mode word whose second beat has error=1 -> out_error_o=1 on that word only, and error=0 on the next word.
REQ-040 SHALL be verified with FifoDepth=2 and out_ready_i=0 for 6 dual-mode beats -> rx_ready_o falls after the 4th beat; no loss or reordering once out_ready_i rises.
REQ-041 SHALL be verified with phys_in_use_i toggled after the first beat of a word -> that word keeps its original mode, and the next word uses the new mode.
REQ-042 SHALL be verified with rst_ni pulsed low while FSM=FILL and one word is buffered -> out_valid_o=0 and busy_o=0 immediately, and the next burst packs from k=0.
